// File: rtl/fast_msg_sequencer.sv
// FAST message sequencer: frames aligner lanes into PMAP / TID / body and serialises body fields.
// Optional build macro FAST_SEQ_PMAP_GATE_EN enables PMAP-driven TID reuse and slot skipping.
module fast_msg_sequencer #(
  parameter int unsigned SUP_PATHS     = 4,
  parameter int unsigned FIELD_W       = 64,
  parameter int unsigned NUM_TEMPLATES = 4,
  parameter int unsigned MAX_FIELDS    = 10,
  parameter int unsigned TID_W         = 8,
  parameter int unsigned PMAP_W        = 16
) (
  input  logic                                 clk,
  input  logic                                 rst,
  input  logic [SUP_PATHS*FIELD_W-1:0]         in_data,
  input  logic [SUP_PATHS-1:0]                 in_valid,
  output logic                                 in_ready,
  input  logic                                 cfg_we,
  input  logic [$clog2(NUM_TEMPLATES)-1:0]     cfg_idx,
  input  logic [$clog2(MAX_FIELDS+1)-1:0]      cfg_count,
  output logic [$clog2(MAX_FIELDS+1)-1:0]      message_field_count,
  output logic                                 out_valid,
  input  logic                                 out_ready,
  output logic [FIELD_W-1:0]                   out_data,
  output logic [$clog2(MAX_FIELDS)-1:0]        out_slot,
  output logic [TID_W-1:0]                     out_tid,
  output logic                                 out_last,
  output logic [PMAP_W-1:0]                    out_pmap,
  output logic                                 msg_done,
  output logic                                 err_tid,
  output logic [15:0]                          err_count
);

  localparam int unsigned IDX_W  = $clog2(NUM_TEMPLATES);
  localparam int unsigned CNT_W  = $clog2(MAX_FIELDS + 1);
  localparam int unsigned SLOT_W = $clog2(MAX_FIELDS);
  localparam int unsigned LANE_W = (SUP_PATHS > 1) ? $clog2(SUP_PATHS) : 1;

  typedef enum logic [1:0] {S_PMAP, S_TID, S_BODY} state_t;

  state_t                        state_q, state_d;
  logic [SUP_PATHS*FIELD_W-1:0]  hold_data_q;
  logic                          hold_full_q;
  logic [LANE_W-1:0]             cur_q, last_q, in_last;
  logic [CNT_W-1:0]              tbl_cnt_q [NUM_TEMPLATES];
  logic [NUM_TEMPLATES-1:0]      tbl_vld_q;
  logic [PMAP_W-1:0]             pmap_q, pmap_d;
  logic [TID_W-1:0]              tid_q, tid_d;
  logic [CNT_W-1:0]              cnt_q, cnt_d;
  logic [SLOT_W-1:0]             slot_q, slot_d;
  logic [15:0]                   err_cnt_q;
  logic                          consume, last_consume, accept;

  logic [FIELD_W-1:0] lanes [SUP_PATHS];
  logic [FIELD_W-1:0] cur_field;
  logic [TID_W-1:0]   tid_lane;
  logic [IDX_W-1:0]   tid_idx;
  logic [CNT_W-1:0]   lookup_cnt;
  logic               tid_ok;

  for (genvar l = 0; l < SUP_PATHS; l++) begin : g_lane
    assign lanes[l] = hold_data_q[l*FIELD_W +: FIELD_W];
  end

  assign cur_field  = lanes[cur_q];
  assign tid_lane   = cur_field[TID_W-1:0];
  assign tid_idx    = tid_lane[IDX_W-1:0];
  assign lookup_cnt = tbl_cnt_q[tid_idx];
  assign tid_ok     = (32'(tid_lane) < NUM_TEMPLATES) && tbl_vld_q[tid_idx];

  // Highest valid lane of the incoming group (valid lanes are contiguous from lane 0)
  always_comb begin
    in_last = '0;
    for (int unsigned i = 0; i < SUP_PATHS; i++) begin
      if (in_valid[i]) in_last = LANE_W'(i);
    end
  end

`ifdef FAST_SEQ_PMAP_GATE_EN
  // Lowest present body slot at or above 'from' and below the template count
  function automatic logic [SLOT_W:0] find_slot(input logic [PMAP_W-1:0] pm,
                                                input int unsigned       from,
                                                input logic [CNT_W-1:0]  cnt);
    logic [SLOT_W:0] res;
    res = '0;
    for (int unsigned s = 0; s < MAX_FIELDS; s++) begin
      if (!res[SLOT_W] && s >= from && s < 32'(cnt) && (s + 1) < PMAP_W) begin
        if (pm[s+1]) res = {1'b1, SLOT_W'(s)};
      end
    end
    return res;
  endfunction

  logic [SLOT_W:0] nxt_srch, first_tid, first_pm;
  assign nxt_srch  = find_slot(pmap_q, 32'(slot_q) + 32'd1, cnt_q);
  assign first_tid = find_slot(pmap_q, 32'd0, lookup_cnt);
  assign first_pm  = find_slot(cur_field[PMAP_W-1:0], 32'd0, cnt_q);
  assign out_last  = out_valid && !nxt_srch[SLOT_W];
`else
  assign out_last  = out_valid && ((32'(slot_q) + 32'd1) == 32'(cnt_q));
`endif

  assign out_valid           = hold_full_q && (state_q == S_BODY);
  assign out_data            = cur_field;
  assign out_slot            = slot_q;
  assign out_tid             = tid_q;
  assign out_pmap            = pmap_q;
  assign message_field_count = cnt_q;
  assign err_count           = err_cnt_q;

  assign last_consume = consume && (cur_q == last_q);
  assign in_ready     = !hold_full_q || last_consume;
  assign accept       = in_ready && (|in_valid);

  // Next-state and per-lane control
  always_comb begin
    state_d  = state_q;
    consume  = 1'b0;
    pmap_d   = pmap_q;
    tid_d    = tid_q;
    cnt_d    = cnt_q;
    slot_d   = slot_q;
    msg_done = 1'b0;
    err_tid  = 1'b0;
    unique case (state_q)
      S_PMAP: begin
        if (hold_full_q) begin
          consume = 1'b1;
          pmap_d  = cur_field[PMAP_W-1:0];
`ifdef FAST_SEQ_PMAP_GATE_EN
          if (cur_field[0]) begin
            state_d = S_TID;
          end else if (first_pm[SLOT_W]) begin
            slot_d  = first_pm[SLOT_W-1:0];
            state_d = S_BODY;
          end else begin
            msg_done = 1'b1;
          end
`else
          state_d = S_TID;
`endif
        end
      end
      S_TID: begin
        if (hold_full_q) begin
          consume = 1'b1;
          state_d = S_PMAP;
          if (!tid_ok) begin
            err_tid = 1'b1;
          end else begin
            tid_d = tid_lane;
            cnt_d = lookup_cnt;
`ifdef FAST_SEQ_PMAP_GATE_EN
            if (first_tid[SLOT_W]) begin
              slot_d  = first_tid[SLOT_W-1:0];
              state_d = S_BODY;
            end else begin
              msg_done = 1'b1;
            end
`else
            if (lookup_cnt == '0) begin
              msg_done = 1'b1;
            end else begin
              slot_d  = '0;
              state_d = S_BODY;
            end
`endif
          end
        end
      end
      S_BODY: begin
        if (out_valid && out_ready) begin
          consume = 1'b1;
`ifdef FAST_SEQ_PMAP_GATE_EN
          slot_d = nxt_srch[SLOT_W-1:0];
`else
          slot_d = slot_q + SLOT_W'(1);
`endif
          if (out_last) begin
            msg_done = 1'b1;
            state_d  = S_PMAP;
          end
        end
      end
      default: state_d = S_PMAP;
    endcase
  end

  // FSM and message context registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_PMAP;
      pmap_q    <= '0;
      tid_q     <= '0;
      cnt_q     <= '0;
      slot_q    <= '0;
      err_cnt_q <= '0;
    end else begin
      state_q <= state_d;
      pmap_q  <= pmap_d;
      tid_q   <= tid_d;
      cnt_q   <= cnt_d;
      slot_q  <= slot_d;
      if (err_tid && (err_cnt_q != 16'hFFFF)) err_cnt_q <= err_cnt_q + 16'd1;
    end
  end

  // Holding register; refilled in the same cycle its last lane drains
  always_ff @(posedge clk) begin
    if (rst) begin
      hold_data_q <= '0;
      hold_full_q <= 1'b0;
      cur_q       <= '0;
      last_q      <= '0;
    end else if (accept) begin
      hold_data_q <= in_data;
      hold_full_q <= 1'b1;
      cur_q       <= '0;
      last_q      <= in_last;
    end else if (last_consume) begin
      hold_full_q <= 1'b0;
    end else if (consume) begin
      cur_q <= cur_q + LANE_W'(1);
    end
  end

  // Template table; a lookup in the write cycle sees the old entry
  always_ff @(posedge clk) begin
    if (rst) begin
      tbl_vld_q <= '0;
      for (int unsigned i = 0; i < NUM_TEMPLATES; i++) tbl_cnt_q[i] <= '0;
    end else if (cfg_we) begin
      tbl_vld_q[cfg_idx] <= 1'b1;
      tbl_cnt_q[cfg_idx] <= cfg_count;
    end
  end

endmodule

// File: doc/fast_msg_sequencer.md
Name: fast_msg_sequencer

Overview:
- Sits directly downstream of the FAST field aligner, on the same clock.
- Takes the aligner's superscalar field lanes and tracks message framing: PMAP, then template ID (TID), then body fields.
- Looks up the per-template field count in a configurable table and drives it back to the aligner.
- Serialises body fields, one per cycle under a valid/ready handshake, to the field decoders, tagged with slot index, TID and last-field flag.

Parameters:
- SUP_PATHS, 4, number of aligner lanes per input group.
- FIELD_W, 64, data bits per field (stop bits already stripped).
- NUM_TEMPLATES, 4, template table entries.
- MAX_FIELDS, 10, maximum body fields per template.
- TID_W, 8, TID bits taken from field[TID_W-1:0].
- PMAP_W, 16, PMAP bits taken from field[PMAP_W-1:0].

Ports:
- clk  in  1  clock, all logic on rising edge.
- rst  in  1  synchronous active-high reset.
- in_data  in  SUP_PATHS*FIELD_W  lane group; lane L at [L*FIELD_W +: FIELD_W].
- in_valid  in  SUP_PATHS  per-lane valid; valid lanes are contiguous from lane 0.
- in_ready  out  1  group accepted when in_ready & |in_valid.
- cfg_we  in  1  template table write strobe.
- cfg_idx  in  $clog2(NUM_TEMPLATES)  entry written.
- cfg_count  in  $clog2(MAX_FIELDS+1)  body field count; entry marked valid on write.
- message_field_count  out  $clog2(MAX_FIELDS+1)  count of current template, to the aligner.
- out_valid  out  1  body field valid.
- out_ready  in  1  downstream accept.
- out_data  out  FIELD_W  body field.
- out_slot  out  $clog2(MAX_FIELDS)  template slot index.
- out_tid  out  TID_W  TID of current message.
- out_last  out  1  final body field of message.
- out_pmap  out  PMAP_W  PMAP of current message.
- msg_done  out  1  one-cycle pulse at message completion.
- err_tid  out  1  one-cycle pulse on unknown or unconfigured TID.
- err_count  out  16  saturating count of err_tid pulses.

Behaviour:
- Reset (synchronous, rst=1 at a clock edge):
  - All outputs 0 except in_ready=1.
  - Table valid bits cleared; FSM to S_PMAP; holding register emptied.
  - Reset mid-message abandons the message with no msg_done.
- Input buffering:
  - One holding register stores the group plus a lane cursor.
  - in_ready = holding empty OR (the last remaining valid lane is consumed this cycle).
  - The same-cycle refill gives back-to-back groups without a bubble.
- Lane consumption:
  - One lane per cycle, lowest index first.
  - PMAP and TID lanes are consumed internally in one cycle each, no out_valid.
  - A body lane is consumed only when out_valid & out_ready.
- Latency: a field in the group accepted at edge N appears on out_* at the earliest in cycle N+1; one field per cycle thereafter.
- FSM states:
  - S_PMAP: latch out_pmap from the lane, go to S_TID.
  - S_TID: idx = tid[$clog2(NUM_TEMPLATES)-1:0].
    - If tid >= NUM_TEMPLATES or the entry is invalid: pulse err_tid, increment err_count (saturating at 0xFFFF), return to S_PMAP.
    - Otherwise latch out_tid and message_field_count.
    - If count == 0: pulse msg_done, go to S_PMAP.
    - Else clear the slot counter, go to S_BODY.
  - S_BODY: emit the lane with out_slot = counter.
    - On the handshake, increment the counter.
    - out_last = (counter == count-1); a handshake with out_last pulses msg_done the same cycle and goes to S_PMAP.
- Output hold: out_data, out_slot and out_last stay stable while out_valid & ~out_ready.
- Message boundaries: a message may end mid-group; the next lane in the same group is the following message's PMAP, with no bubble.
- Configuration:
  - A table write in the same cycle as a TID lookup of that entry: the lookup sees the old value.
  - message_field_count holds its value between messages.

Optional Feature:
- Macro: FAST_SEQ_PMAP_GATE_EN.
- Defined:
  - PMAP bit 0 = TID present; bit s+1 = body slot s present.
  - If bit 0 = 0, the previous out_tid and count are reused, and the first lane after PMAP is treated as body.
  - The slot counter skips absent slots; out_slot carries the true slot index.
  - out_last is set on the last present slot < count.
  - If no slots are present, msg_done pulses immediately after TID.
- Undefined:
  - Every message carries PMAP then TID.
  - PMAP is latched but ignored; slots are strictly sequential.

Test Plan:
1. Table: idx 2 = count 3. Group 1: in_valid=1111, PMAP=0x7F, TID=2, A, B. Group 2: in_valid=0001, C. out_ready held 1. -> out A/0, B/1, C/2; out_last and msg_done on C; out_tid=2; message_field_count=3.
2. Same stream, out_ready low for 5 cycles at B. -> B held stable; in_ready=0; no loss or duplication; C follows B.
3. TID=9 (NUM_TEMPLATES=4). -> err_tid pulse, err_count=1, no out_valid; the next lane is parsed as PMAP.
4. idx 1 = count 0; one group PMAP, TID=1, PMAP, TID=1. -> two msg_done pulses, no out_valid.
5. rst asserted after A during message 1. -> all outputs 0 next cycle; in_ready=1; the table must be rewritten; the message from test 1 then passes cleanly.
6. With FAST_SEQ_PMAP_GATE_EN, idx 0 = count 4, PMAP=0b10101 (TID, slot 1, slot 3 present), TID=0, X, Y. -> X/1 then Y/3 with out_last; msg_done.
